// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush, data-memory wait
// with timeout-to-halt, plus stall and flush statistics counters.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_rd,
  input  logic [4:0]  IF_ID_rs1,
  input  logic [4:0]  IF_ID_rs2,
  input  logic        IF_ID_uses_rs2,
  input  logic        branch_taken_ex,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_hold,
  output logic        mem_wb_bubble,
  output logic        mem_err,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMemWait = 2'd1;
  localparam logic [1:0] StHalt    = 2'd2;

  localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];

  logic        load_use;
  logic        mem_stall;
  logic [1:0]  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  // A load into x0 never creates a dependency; rs2 only matters when it is read.
  assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                    ((ID_EX_rd == IF_ID_rs1) || (IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));
  assign mem_stall = dmem_req && !dmem_ready;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d    = StMemWait;
          wait_cnt_d = 8'd1;
        end
      end
      StMemWait: begin
        if (!mem_stall) begin
          state_d    = StRun;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == TimeoutCnt) begin
          state_d    = StHalt;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = 8'd0;
      end
    endcase
    mem_err_d = mem_err_q || (state_d == StHalt);
  end

  // Control priority: reset > halt > memory stall > branch > load-use > normal.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (state_q == StHalt || mem_stall) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ex_mem_hold   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (branch_taken_ex) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StRun;
      wait_cnt_q     <= 8'd0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      if (!pc_write && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (if_id_flush && (flush_count_q != 16'hFFFF)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign state        = state_q;
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational control table plus multi-cycle
// sequences for memory wait, timeout/halt, branch-during-wait and async reset.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        rst1;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_rd;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;
  logic        IF_ID_uses_rs2;
  logic        branch_taken_ex;
  logic        dmem_req;
  logic        dmem_ready;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, mem_wb_bubble;
  logic        mem_err;
  logic [1:0]  state;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic        pc_write1, if_id_write1, if_id_flush1, id_ex_flush1, ex_mem_hold1, mem_wb_bubble1;
  logic        mem_err1;
  logic [1:0]  state1;
  logic [31:0] stall_cycles1;
  logic [15:0] flush_count1;

  int checks;
  int failures;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, mem_wb_bubble}
  logic [5:0] ctl;
  assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, mem_wb_bubble};

  localparam logic [5:0] CtlNorm  = 6'b110000;
  localparam logic [5:0] CtlLoad  = 6'b000100;
  localparam logic [5:0] CtlBr    = 6'b111100;
  localparam logic [5:0] CtlHold  = 6'b000011;
  localparam logic [5:0] CtlReset = 6'b001101;

  hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .IF_ID_uses_rs2(IF_ID_uses_rs2),
    .branch_taken_ex(branch_taken_ex), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_hold(ex_mem_hold), .mem_wb_bubble(mem_wb_bubble),
    .mem_err(mem_err), .state(state), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_ctrl #(.TIMEOUT(1)) dut1 (
    .clk(clk), .rst(rst1),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .IF_ID_uses_rs2(IF_ID_uses_rs2),
    .branch_taken_ex(branch_taken_ex), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write1), .if_id_write(if_id_write1), .if_id_flush(if_id_flush1),
    .id_ex_flush(id_ex_flush1), .ex_mem_hold(ex_mem_hold1), .mem_wb_bubble(mem_wb_bubble1),
    .mem_err(mem_err1), .state(state1), .stall_cycles(stall_cycles1),
    .flush_count(flush_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       memread;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses;
    logic       br;
    logic       req;
    logic       rdy;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input vec_t v);
    ID_EX_MemRead   = v.memread;
    ID_EX_rd        = v.rd;
    IF_ID_rs1       = v.rs1;
    IF_ID_rs2       = v.rs2;
    IF_ID_uses_rs2  = v.uses;
    branch_taken_ex = v.br;
    dmem_req        = v.req;
    dmem_ready      = v.rdy;
  endtask

  task automatic clear_in();
    set_in('0);
  endtask

  // Asserts rst across one rising edge, checks the forced outputs, releases on a falling edge.
  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    @(negedge clk);
    check("rst_ctl", 32'(ctl), 32'(CtlReset));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    rst1     = 1'b1;
    clear_in();

    //            memread rd     rs1    rs2    uses  br    req   rdy   exp
    vecs[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, CtlNorm};
    vecs[1]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, CtlLoad};
    vecs[2]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, CtlNorm};
    vecs[3]  = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, CtlNorm};
    vecs[4]  = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, CtlLoad};
    vecs[5]  = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, CtlNorm};
    vecs[6]  = '{1'b0, 5'd0, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, CtlBr};
    vecs[7]  = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, CtlBr};
    vecs[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, CtlHold};
    vecs[9]  = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, CtlHold};
    vecs[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, CtlBr};
    vecs[11] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, CtlNorm};

    // Reset state
    @(negedge clk);
    check("reset_ctl", 32'(ctl), 32'(CtlReset));
    check("reset_state", 32'(state), 32'd0);
    check("reset_stall", stall_cycles, 32'd0);
    check("reset_flush", 32'(flush_count), 32'd0);
    check("reset_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Combinational control table
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      set_in(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(ctl), 32'(vecs[i].exp));
    end

    // Single load-use bubble
    do_reset();
    @(posedge clk); #1;
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5; IF_ID_rs1 = 5'd5;
    @(negedge clk);
    check("lu_ctl", 32'(ctl), 32'(CtlLoad));
    @(posedge clk); #1;
    clear_in();
    @(negedge clk);
    check("lu_after_ctl", 32'(ctl), 32'(CtlNorm));
    check("lu_stall_cycles", stall_cycles, 32'd1);

    // Three-cycle memory wait
    do_reset();
    @(posedge clk); #1;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("mw_hold%0d", k), 32'(ex_mem_hold), 32'd1);
      check($sformatf("mw_state%0d", k), 32'(state), (k == 0) ? 32'd0 : 32'd1);
    end
    @(posedge clk); #1;
    dmem_ready = 1'b1;
    @(negedge clk);
    check("mw_ready_state", 32'(state), 32'd1);
    check("mw_ready_ctl", 32'(ctl), 32'(CtlNorm));
    check("mw_stall_cycles", stall_cycles, 32'd3);
    @(posedge clk); #1;
    clear_in();
    @(negedge clk);
    check("mw_back_run", 32'(state), 32'd0);
    check("mw_stall_final", stall_cycles, 32'd3);

    // Branch held across a memory wait lands on the ready cycle
    do_reset();
    @(posedge clk); #1;
    branch_taken_ex = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd2; IF_ID_rs1 = 5'd2;
    @(negedge clk);
    check("bw_hold0", 32'(ctl), 32'(CtlHold));
    @(negedge clk);
    check("bw_hold1", 32'(ctl), 32'(CtlHold));
    @(posedge clk); #1;
    dmem_ready = 1'b1;
    @(negedge clk);
    check("bw_ready_ctl", 32'(ctl), 32'(CtlBr));
    @(posedge clk); #1;
    clear_in();
    @(negedge clk);
    check("bw_flush_count", 32'(flush_count), 32'd1);
    @(posedge clk); #1;
    branch_taken_ex = 1'b1; ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd2; IF_ID_rs1 = 5'd2;
    @(negedge clk);
    check("br_lu_ctl", 32'(ctl), 32'(CtlBr));
    @(posedge clk); #1;
    clear_in();
    @(negedge clk);
    check("br_lu_flush_count", 32'(flush_count), 32'd2);
    check("br_lu_stall", stall_cycles, 32'd2);

    // Timeout to halt (TIMEOUT=4), sticky error, cleared by reset
    do_reset();
    @(posedge clk); #1;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("to_state%0d", k), 32'(state), (k == 1) ? 32'd0 : 32'd1);
      check($sformatf("to_err%0d", k), 32'(mem_err), 32'd0);
    end
    @(negedge clk);
    check("to_halt_state", 32'(state), 32'd2);
    check("to_halt_err", 32'(mem_err), 32'd1);
    check("to_halt_ctl", 32'(ctl), 32'(CtlHold));
    check("to_halt_stall", stall_cycles, 32'd5);
    @(posedge clk); #1;
    dmem_req = 1'b0; dmem_ready = 1'b1;
    @(negedge clk);
    check("to_frozen_state", 32'(state), 32'd2);
    check("to_frozen_ctl", 32'(ctl), 32'(CtlHold));
    check("to_sticky_err", 32'(mem_err), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("to_rst_state", 32'(state), 32'd0);
    check("to_rst_err", 32'(mem_err), 32'd0);
    check("to_rst_stall", stall_cycles, 32'd0);
    check("to_rst_ctl", 32'(ctl), 32'(CtlReset));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("to_release_state", 32'(state), 32'd0);
    check("to_release_ctl", 32'(ctl), 32'(CtlNorm));
    check("to_release_err", 32'(mem_err), 32'd0);

    // Async reset between edges during a memory wait
    do_reset();
    @(posedge clk); #1;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    branch_taken_ex = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("ar_pre_state", 32'(state), 32'd1);
    check("ar_pre_stall", stall_cycles, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("ar_state", 32'(state), 32'd0);
    check("ar_stall", stall_cycles, 32'd0);
    check("ar_flush", 32'(flush_count), 32'd0);
    clear_in();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ar_fresh_wait_state", 32'(state), 32'd1);
    @(posedge clk); #1;
    clear_in();

    // TIMEOUT=1: second consecutive stall cycle halts
    rst = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    @(posedge clk); #1;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    check("t1_state0", 32'(state1), 32'd0);
    @(negedge clk);
    check("t1_state1", 32'(state1), 32'd1);
    check("t1_err1", 32'(mem_err1), 32'd0);
    @(negedge clk);
    check("t1_halt", 32'(state1), 32'd2);
    check("t1_err", 32'(mem_err1), 32'd1);
    check("t1_ctl", 32'({pc_write1, if_id_write1, if_id_flush1, id_ex_flush1,
                         ex_mem_hold1, mem_wb_bubble1}), 32'(CtlHold));
    rst1 = 1'b1;
    clear_in();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
